// File: rtl/sys_west_feeder.sv
// West-edge feeder: FIFO-buffered vectors, optional weight-switch slot, diagonal row skew.
// Optional stall counter (stall_cnt/stall_clr) enabled by defining FEEDER_PERF_EN.
module sys_west_feeder #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ROWS*DATA_WIDTH-1:0]   in_vec,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  input  logic                         sw_req,
  output logic [ROWS*DATA_WIDTH-1:0]   out_input,
  output logic [ROWS-1:0]              out_valid,
  output logic [ROWS-1:0]              out_switch,
  output logic                         tile_done,
  output logic                         busy
`ifdef FEEDER_PERF_EN
  ,
  input  logic                         stall_clr,
  output logic [31:0]                  stall_cnt
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned VW = ROWS * DATA_WIDTH;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_SWITCH, ST_STREAM} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [VW-1:0]   mem_q [DEPTH];
  logic [VW-1:0]   mem_d [DEPTH];
  logic [DEPTH-1:0] last_mem_q, last_mem_d;
  logic            sw_pending_q, sw_pending_d;
  logic [ROWS-1:0] valid_q, valid_d, switch_q, switch_d, last_q, last_d;

  logic            push, pop, fifo_empty;
  logic            slot_valid, slot_switch, slot_last;
  logic [VW-1:0]   slot_data;

  assign fifo_empty = (count_q == '0);
  assign in_ready   = (count_q != FULL_CNT);
  assign push       = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    slot_valid  = 1'b0;
    slot_switch = 1'b0;
    slot_last   = 1'b0;
    slot_data   = '0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = (sw_pending_q || sw_req) ? ST_SWITCH : ST_STREAM;
      end
      ST_SWITCH: begin
        slot_switch = 1'b1;
        state_d     = ST_STREAM;
      end
      ST_STREAM: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          slot_valid = 1'b1;
          slot_data  = mem_q[rd_ptr_q];
          slot_last  = last_mem_q[rd_ptr_q];
          if (slot_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A request arriving in the same cycle the switch slot issues is kept for the next tile.
  assign sw_pending_d = (sw_pending_q && !slot_switch) || sw_req;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q;
    mem_d      = mem_q;
    last_mem_d = last_mem_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push) begin
      mem_d[wr_ptr_q]      = in_vec;
      last_mem_d[wr_ptr_q] = in_last;
    end
  end

  always_comb begin
    valid_d  = {valid_q[ROWS-2:0], slot_valid};
    switch_d = {switch_q[ROWS-2:0], slot_switch};
    last_d   = {last_q[ROWS-2:0], slot_valid && slot_last};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      sw_pending_q <= 1'b0;
      valid_q      <= '0;
      switch_q     <= '0;
      last_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      sw_pending_q <= sw_pending_d;
      valid_q      <= valid_d;
      switch_q     <= switch_d;
      last_q       <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q      <= mem_d;
    last_mem_q <= last_mem_d;
  end

  // Row r keeps a private r+1 deep lane chain; newest entry at the LSB end.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [(r+1)*DATA_WIDTH-1:0] lane_q, lane_d;
    if (r == 0) begin : g_first
      always_comb lane_d = slot_data[DATA_WIDTH-1:0];
    end else begin : g_rest
      always_comb lane_d = {lane_q[r*DATA_WIDTH-1:0], slot_data[r*DATA_WIDTH +: DATA_WIDTH]};
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) lane_q <= '0;
      else     lane_q <= lane_d;
    end
    assign out_input[r*DATA_WIDTH +: DATA_WIDTH] = lane_q[(r+1)*DATA_WIDTH-1 -: DATA_WIDTH];
  end

  assign out_valid  = valid_q;
  assign out_switch = switch_q;
  assign tile_done  = valid_q[ROWS-1] && last_q[ROWS-1];
  assign busy       = (state_q != ST_IDLE) || (|valid_q) || (|switch_q);

`ifdef FEEDER_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        bubble;

  assign bubble = (state_q == ST_STREAM) && fifo_empty;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr)                        stall_cnt_d = '0;
    else if (bubble && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sys_west_feeder.sv
// Scoreboard bench for sys_west_feeder: per-row expected slot queues, skew timing, tile_done.
module tb_sys_west_feeder;
  localparam int ROWS = 4;
  localparam int DW   = 16;
  localparam int VW   = ROWS * DW;

  typedef struct {
    bit                   sw;
    logic signed [DW-1:0] data;
    bit                   last;
    int                   t;
  } item_t;

  logic            clk = 0, rst = 1;
  logic [VW-1:0]   in_vec = '0;
  logic            in_valid = 0, in_last = 0, sw_req = 0;
  logic            in_ready, tile_done, busy;
  logic [VW-1:0]   out_input;
  logic [ROWS-1:0] out_valid, out_switch;
`ifdef FEEDER_PERF_EN
  logic            stall_clr = 0;
  logic [31:0]     stall_cnt;
`endif

  sys_west_feeder #(.ROWS(ROWS), .DATA_WIDTH(DW), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .sw_req(sw_req), .out_input(out_input), .out_valid(out_valid),
    .out_switch(out_switch), .tile_done(tile_done), .busy(busy)
`ifdef FEEDER_PERF_EN
    , .stall_clr(stall_clr), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    n_cmp = 0, n_bad = 0;
  item_t expq [ROWS][$];
  int    tq   [ROWS][$];
  bit    pend = 0, tile_start = 1, sw_hold = 0, saw_full = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic bit all_empty();
    for (int r = 0; r < ROWS; r++) if (expq[r].size() != 0) return 0;
    return 1;
  endfunction

  task automatic flush();
    for (int r = 0; r < ROWS; r++) begin expq[r].delete(); tq[r].delete(); end
    pend = 0; tile_start = 1;
  endtask

  // Reference: a tile's first vector is preceded by one switch slot when a request is pending.
  task automatic enqueue(input logic [VW-1:0] v, input bit last, input int t);
    item_t it;
    if (tile_start && pend) begin
      for (int r = 0; r < ROWS; r++) begin
        it.sw = 1; it.data = '0; it.last = 0; it.t = (t >= 0) ? t - 1 : -1;
        expq[r].push_back(it);
      end
      pend = 0;
    end
    for (int r = 0; r < ROWS; r++) begin
      it.sw = 0; it.data = v[r*DW +: DW]; it.last = last; it.t = t;
      expq[r].push_back(it);
    end
    tile_start = last;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [VW-1:0] v, input bit last, input bit sw, input int t);
    int waited = 0;
    in_vec = v; in_valid = 1; in_last = last; sw_req = sw | sw_hold;
    if (sw | sw_hold) pend = 1;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      saw_full = 1;
      tick(); @(negedge clk); waited++;
    end
    if (!in_ready) chk("push_timeout", 0, 1);
    else enqueue(v, last, t);
    tick();
    in_valid = 0; in_last = 0; in_vec = '0; sw_req = sw_hold;
  endtask

  task automatic drain();
    int w = 0;
    while (!all_empty() && w < 400) begin tick(); w++; end
    if (!all_empty()) begin chk("drain_timeout", 0, 1); flush(); end
    tick(); tick();
  endtask

  function automatic logic [VW-1:0] pack4(input logic [DW-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Monitor: pops an expected slot whenever a row presents valid or switch.
  always @(negedge clk) begin
    item_t it;
    logic [DW-1:0] d;
    if (!rst) begin
      for (int r = 0; r < ROWS; r++) begin
        d = out_input[r*DW +: DW];
        if (out_valid[r] || out_switch[r]) begin
          if (expq[r].size() == 0) chk($sformatf("unexpected_slot_row%0d", r), 1, 0);
          else begin
            it = expq[r].pop_front();
            chk($sformatf("switch_row%0d", r), out_switch[r], it.sw);
            chk($sformatf("valid_row%0d", r), out_valid[r], !it.sw);
            chk($sformatf("data_row%0d", r), $signed(d), it.data);
            if (r == 0) begin
              if (it.t >= 0) chk("abs_time_row0", cyc, it.t);
              for (int k = 1; k < ROWS; k++) tq[k].push_back(cyc + k);
            end else if (tq[r].size() != 0) begin
              chk($sformatf("skew_row%0d", r), cyc, tq[r].pop_front());
            end
            if (r == ROWS-1) chk("tile_done", tile_done, !it.sw && it.last);
          end
        end else begin
          chk($sformatf("idle_data_row%0d", r), d, 0);
          if (r == ROWS-1) chk("tile_done_idle", tile_done, 0);
        end
      end
    end
  end

  initial begin
    int n;
    logic [VW-1:0] v;
    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_switch", out_switch, 0);
    chk("rst_out_input", out_input, 0);
    chk("rst_tile_done", tile_done, 0);
    tick();

    // Switch then two-vector tile, absolute timing
    n = cyc;
    send(pack4(1, 2, 3, 4), 0, 1, n + 4);
    send(pack4(5, 6, 7, 8), 1, 0, n + 5);
    drain();

    // Continuous switch requests with one-vector tiles until the FIFO fills
    sw_hold = 1; saw_full = 0;
    for (int i = 0; i < 10; i++) send(pack4(16'(i), 16'(i+20), 16'(i+40), 16'(i+60)), 1, 0, -1);
    chk("fifo_full_seen", saw_full, 1);
    drain();
    sw_hold = 0; sw_req = 0;
    pend = 1;

    // Reset mid-tile
    n = cyc;
    send(pack4(9, 9, 9, 9), 0, 0, -1);
    send(pack4(8, 8, 8, 8), 0, 0, -1);
    send(pack4(7, 7, 7, 7), 1, 0, -1);
    tick(); tick();
    rst = 1;
    flush();
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_switch", out_switch, 0);
    chk("mid_rst_out_input", out_input, 0);
    chk("mid_rst_tile_done", tile_done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    tick(); rst = 0; tick(); tick();

    // Bubble inside a tile
`ifdef FEEDER_PERF_EN
    stall_clr = 1; tick(); stall_clr = 0;
`endif
    n = cyc;
    send(pack4(11, 12, 13, 14), 0, 0, n + 3);
    tick(); tick();
    send(pack4(21, 22, 23, 24), 0, 0, n + 5);
    send(pack4(31, 32, 33, 34), 1, 0, n + 6);
    drain();
`ifdef FEEDER_PERF_EN
    chk("stall_cnt", stall_cnt, 1);
`endif

    // Switch requested while tile A streams applies only to tile B
    n = cyc;
    send(pack4(101, 102, 103, 104), 0, 0, n + 3);
    send(pack4(105, 106, 107, 108), 0, 0, n + 4);
    send(pack4(109, 110, 111, 112), 0, 0, n + 5);
    send(pack4(113, 114, 115, 116), 1, 1, n + 6);
    send(pack4(201, 202, 203, 204), 0, 1, n + 9);
    send(pack4(205, 206, 207, 208), 1, 0, n + 10);
    drain();

    // Signed extremes
    n = cyc;
    send(pack4(16'h8000, 16'h1234, 16'hABCD, 16'h7FFF), 1, 0, n + 3);
    drain();

    // Randomized tiles
    for (int tile = 0; tile < 25; tile++) begin
      int len;
      bit sw;
      len = $urandom_range(1, 4);
      sw  = ($urandom_range(0, 2) == 0);
      if (sw) drain();
      for (int k = 0; k < len; k++) begin
        v = {$urandom, $urandom};
        send(v, k == len - 1, sw && k == 0, -1);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
      end
    end
    drain();
    @(negedge clk);
    chk("end_busy", busy, 0);
    chk("end_in_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
